// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo up/down counter.
// Build option: define MOD_COUNTER_SAT_EN to honour the sat input;
// otherwise the counter always wraps.
package mod_counter_pkg;

    // Counting direction as carried on the 'up' input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Behaviour at the ends of the 0..limit range.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Default counter, data and limit width.
    localparam int DEFAULT_WIDTH = 5;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_next.sv
// Combinational next-value / terminal-event unit for mod_counter.
// Given the current count, the inclusive limit, the direction and the
// end-of-range mode, it produces the value one enabled step would
// reach and whether that step is a terminal event.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] next,
    output logic             term_evt
);

    dir_e  dir;
    mode_e mode;

    assign dir  = dir_e'(up);
    assign mode = mode_e'(sat);

    // Step rules. Counting up, anything at or beyond the limit (the limit
    // may have shrunk under us) is a terminal event. Counting down, any
    // non-zero count simply decrements, which also walks an out-of-range
    // count back towards the legal range; only zero is terminal.
    always_comb begin
        next     = count;
        term_evt = 1'b0;
        if (dir == DIR_UP) begin
            if (count < limit) begin
                next = count + WIDTH'(1);
            end else begin
                term_evt = 1'b1;
                next     = (mode == MODE_SAT) ? limit : '0;
            end
        end else begin
            if (count != '0) begin
                next = count - WIDTH'(1);
            end else begin
                term_evt = 1'b1;
                next     = (mode == MODE_SAT) ? '0 : limit;
            end
        end
    end

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// Modulo up/down counter with programmable inclusive limit, optional
// saturation, a one-cycle terminal-event pulse (wrap) and a sticky
// overflow flag (ovf).
// Build option: MOD_COUNTER_SAT_EN -- when defined the sat input selects
// saturate vs wrap; when undefined sat is ignored and the counter wraps.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step_evt;
    logic             sat_eff;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_eff = sat;
`else
    logic sat_unused;
    assign sat_unused = sat;
    assign sat_eff    = 1'b0;
`endif

    mod_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count    (count_q),
        .limit    (limit),
        .up       (up),
        .sat      (sat_eff),
        .next     (step_next),
        .term_evt (step_evt)
    );

    // A load above the limit is clamped so the count always starts legal.
    assign load_val = (data <= limit) ? data : limit;

    // Priority load > enable > hold; wrap only reports a step's terminal
    // event, and a fresh event beats a simultaneous ovf clear.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (enable) begin
            count_d = step_next;
            wrap_d  = step_evt;
        end
        ovf_d = wrap_d | (ovf_q & ~clr_ovf);
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign ovf     = ovf_q;
    assign at_term = up ? (count_q == limit) : (count_q == '0);

endmodule : mod_counter

// File: doc/mod_counter.md
# mod_counter

- Parametrised modulo up/down counter for the VeriRISC datapath; the next generation of the basic loadable counter.
- Adds direction control, a run-time programmable terminal limit, wrap or saturate behaviour, a terminal-event pulse and a sticky overflow flag.
- Used for the program counter, loop/delay counters and the cycle-phase sequencer, where a count range other than 0..2^WIDTH-1 is needed.

## Interface
Reset is rst_, asynchronous, active-low; the clock is clk.

Parameters:
- WIDTH, 5, counter, data and limit width (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_  in  1  asynchronous active-low reset
- data  in  WIDTH  parallel load value
- load  in  1  synchronous load; highest priority after reset
- enable  in  1  count one step when load is low
- up  in  1  direction: 1 = increment, 0 = decrement
- limit  in  WIDTH  inclusive maximum; legal range 0..limit
- sat  in  1  1 = saturate at range ends, 0 = wrap (see Configuration)
- clr_ovf  in  1  synchronous clear of ovf
- count  out  WIDTH  current count (registered)
- at_term  out  1  combinational: count == limit when up=1, count == 0 when up=0
- wrap  out  1  registered one-cycle pulse: terminal event on previous edge
- ovf  out  1  registered sticky terminal-event flag

## Operation
- Priority per rising edge: reset > load > enable > hold.
- Load: count <= data when data ≤ limit, else count <= limit. No event, wrap = 0.
- Enable, up=1:
  - count < limit: count+1.
  - count ≥ limit: terminal event; next = 0 (wrap mode) or limit (sat mode).
- Enable, up=0:
  - count > limit: next = count−1, no event.
  - 0 < count ≤ limit: count−1.
  - count == 0: terminal event; next = limit (wrap mode) or 0 (sat mode).
- limit == 0: count stays 0; every enabled step is a terminal event.
- Terminal event: wrap = 1 for exactly the following cycle; ovf set.
- ovf stays set until clr_ovf; if set and clear occur on the same edge, set wins.
- Idle (load=0, enable=0): count, ovf hold; wrap = 0.
- All arithmetic is WIDTH-bit unsigned; the range-end checks prevent any silent modular overflow.
- limit may change at any time; the new value takes effect on the next edge.

## Timing
- Reset values: count = 0, wrap = 0, ovf = 0. at_term follows combinationally (1 with up=0 under reset).
- Reset mid-count clears everything immediately; no pending wrap pulse survives.
- Latency: load/step visible on count one edge after sampling; wrap/ovf update on the same edge as count.
- No handshake; enable may be held high for continuous counting, one step per cycle.
- Back-to-back terminal events (e.g. limit=0, enable held) keep wrap high continuously.

## Configuration
- MOD_COUNTER_SAT_EN defined: sat input honoured as above.
- Undefined: sat ignored, always wrap mode; saturation logic not synthesised. Port list unchanged.

## Structure
- Package mod_counter_pkg holds:
  - typedef enum logic {DIR_DOWN, DIR_UP} dir_e
  - typedef enum logic {MODE_WRAP, MODE_SAT} mode_e
  - constant DEFAULT_WIDTH = 5
- One sub-module, mod_counter_next: combinational next-value/event unit (inputs count, limit, up, sat; outputs next, event).
- Top level holds the count, wrap and ovf registers plus priority logic.

## Test plan
WIDTH=5 for all scenarios.
- Reset: rst_ low mid-count at count=13 → count=0, wrap=0, ovf=0 immediately.
- Up wrap: limit=9, enable held, up=1, from 0 → 0..9, then 0; wrap pulses the cycle count shows 0; ovf=1.
- Down sat (MOD_COUNTER_SAT_EN): sat=1, up=0, count=2 → 1, 0, 0, 0; wrap high on each held step; ovf=1.
  - Same stimulus without the macro → 1, 0, 31 (limit=31).
- Load clamp and priority: limit=20, data=25, load=1 with enable=1 → count=20, wrap=0.
- ovf clear race: terminal event and clr_ovf on the same edge → ovf=1; clr_ovf alone next cycle → ovf=0.
- Limit shrink: count=15, limit changed to 10, enable, up=1 → count=0, wrap=1 (wrap mode).
